sram_controller: RTL
====================

# sram_controller

Memory-side controller that sits directly downstream of the pipeline's MEM stage and replaces its internal data memory with an external 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request, splits it into two 16-bit SRAM transfers with a programmable number of wait cycles each, and deasserts `ready` so the pipeline freezes until the access completes. The top level combines `~ready` into the pipeline-wide freeze.

## Interface
- `WAIT_CYCLES`, default 5: cycles each 16-bit half-transfer occupies the SRAM bus, minimum 1.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `clk` in, 1 bit: the single clock; all state changes on the rising edge.
- `rst` in, 1 bit: reset, asynchronous and active-low.
- `wr_en` in, 1 bit: store request from the MEM stage.
- `rd_en` in, 1 bit: load request from the MEM stage.
- `address` in, 32 bits: byte address, ALU result.
- `write_data` in, 32 bits: store data, Val_Rm.
- `read_data` out, 32 bits: registered load result.
- `ready` out, 1 bit: high when no access is pending or the current access is complete.
- `SRAM_DQ` inout, 16 bits: SRAM data bus.
- `SRAM_ADDR` out, 18 bits: SRAM half-word address.
- `SRAM_WE_N` out, 1 bit: write enable, active-low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N` out, 1 bit each: constant 0.

## Operation
- Address map:
  - `off = address - ADDR_BASE`, 32-bit subtraction with wrap.
  - `word = off[18:2]`; higher bits are ignored, so out-of-range addresses wrap silently.
  - Low half is at `{word,1'b0}`; high half is at `{word,1'b1}`.
- States: IDLE, LOW, HIGH, DONE. A wait counter of width clog2(WAIT_CYCLES+1) runs inside each half.
- IDLE:
  - On `wr_en|rd_en`, latch `address` and `write_data`, latch the operation, clear the counter and go to LOW.
  - If both are asserted, the access is a write; `read_data` is untouched.
- LOW:
  - Drive `SRAM_ADDR={word,0}`.
  - Write: `SRAM_WE_N=0` and drive `SRAM_DQ=wdata[15:0]`.
  - Read: `SRAM_WE_N=1`, `SRAM_DQ` is high-Z, and `SRAM_DQ` is captured into `read_data[15:0]` on the last counter cycle.
  - After WAIT_CYCLES cycles, clear the counter and go to HIGH.
- HIGH: same as LOW using `{word,1}`, bits [31:16], and `read_data[31:16]`. After WAIT_CYCLES cycles, go to DONE.
- DONE: `SRAM_WE_N=1`, `SRAM_DQ` high-Z; go to IDLE unconditionally.
- `ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE when no request is present.
  - 0 in IDLE when a request is present, and 0 in LOW and HIGH.
- Request inputs are ignored outside IDLE; the pipeline holds them stable while frozen.
- `SRAM_DQ` is driven only during LOW and HIGH of a write; otherwise it is high-Z.
- `read_data` holds its value until the next read overwrites it. Writes never change it.

## Timing
- Cycle 0 is the first cycle a request is seen in IDLE; `ready=0` in that cycle.
- Cycles 1..W are LOW and cycles W+1..2W are HIGH.
- Cycle 2W+1 is DONE with `ready=1`. The pipeline advances at the end of that cycle.
- Total stall is 2W+1 cycles (11 at W=5).
- A following request is first seen in cycle 2W+2 (IDLE) and is stalled again from that cycle.
- `read_data` is complete and stable from cycle 2W+1 onward.
- Reset (`rst=0`), at any time including mid-transfer, applies immediately and asynchronously:
  - state = IDLE, counter = 0;
  - `read_data=0`, `SRAM_WE_N=1`, `SRAM_DQ` high-Z, `SRAM_ADDR=0`;
  - `ready` follows the IDLE rule.
- No partial write is completed after reset.

## Test plan
- Reset: hold `rst=0` with no requests -> `ready=1`, `read_data=0`, `SRAM_WE_N=1`, `SRAM_DQ`=Z, strobes 0.
- Write: `wr_en`, `address=1032`, `write_data=0xDEADBEEF`, W=5 ->
  - cycles 1-5: `SRAM_ADDR=4`, `DQ=0xBEEF`, `WE_N=0`;
  - cycles 6-10: `SRAM_ADDR=5`, `DQ=0xDEAD`, `WE_N=0`;
  - cycle 11: `ready=1`, `WE_N=1`;
  - `ready=0` in cycles 0-10.
- Read back: behavioural SRAM model, `rd_en`, `address=1032` -> `read_data=0xDEADBEEF` and `ready=1` at cycle 11; `WE_N` stays 1 and `DQ` is never driven by the DUT.
- Back-to-back: loads from 1024 then 1028 held by a frozen pipeline -> two ready pulses at cycles 11 and 23, each one cycle wide; returns the correct word each time.
- Reset mid-write: assert `rst=0` in cycle 3 of a write -> `WE_N=1` and `DQ`=Z without waiting for a clock edge; state IDLE; SRAM word 5 unchanged.
- Simultaneous `rd_en` and `wr_en`: `address=1024`, `write_data=0x12345678` -> SRAM words 0/1 = 0x5678/0x1234; `read_data` keeps its prior value.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit load/store from the MEM stage into two
// 16-bit transfers on an external asynchronous SRAM, holding ready low while
// the access is in flight.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_en, rd_en        store / load request (store wins if both are high)
//   address             byte address; ADDR_BASE maps to SRAM word 0
//   write_data          store data
//   read_data           registered load result
//   ready               low while an access is pending
//   SRAM_DQ             bidirectional 16-bit SRAM data bus
//   SRAM_ADDR           SRAM half-word address
//   SRAM_WE_N           write enable, active-low
//   SRAM_CE_N/OE_N/UB_N/LB_N  tied active (0)
module sram_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [16:0]   word;
    logic [31:0]   wdata;
    logic          is_wr;

    logic          req;
    logic          last;
    logic          busy;
    logic          drive;
    logic [15:0]   dq_out;
    logic [16:0]   word_in;

    assign req  = wr_en | rd_en;
    assign last = (cnt == CW'(WAIT_CYCLES - 1));
    assign busy = (state == LOW) || (state == HIGH);

    // Offset wraps at 32 bits; bits above the 17-bit word index are dropped.
    assign word_in = 17'((address - 32'(ADDR_BASE)) >> 2);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req) state_nxt = LOW;
            LOW:  if (last) state_nxt = HIGH;
            HIGH: if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            word      <= '0;
            wdata     <= '0;
            is_wr     <= 1'b0;
            read_data <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        word  <= word_in;
                        wdata <= write_data;
                        is_wr <= wr_en;
                        cnt   <= '0;
                    end
                end
                LOW: begin
                    if (!is_wr && last)
                        read_data[15:0] <= SRAM_DQ;
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                HIGH: begin
                    if (!is_wr && last)
                        read_data[31:16] <= SRAM_DQ;
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Bus outputs decode straight from state so reset releases them at once.
    always_comb begin
        SRAM_ADDR = '0;
        dq_out    = wdata[15:0];
        unique case (state)
            LOW:  SRAM_ADDR = {word, 1'b0};
            HIGH: begin
                SRAM_ADDR = {word, 1'b1};
                dq_out    = wdata[31:16];
            end
            default: SRAM_ADDR = '0;
        endcase
    end

    assign drive     = is_wr & busy;
    assign SRAM_WE_N = ~drive;
    assign SRAM_DQ   = drive ? dq_out : 16'hzzzz;

    assign ready = (state == DONE) || ((state == IDLE) && !req);

    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
